ddr_ca_lane_ctrl: RTL and testbench



---
 rtl/ddr_ca_lane_ctrl_if.sv | 58 +++++
 rtl/ddr_ca_lane_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_ddr_ca_lane_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_ca_lane_ctrl_if.sv
// Bus bundle between the fabric-side DDR CA lane controller and its neighbours.
// The master side is the fabric user plus the IOD pins that feed back into the
// controller. The slave side is the controller itself.
interface ddr_ca_lane_ctrl_if #(
    parameter int NUM_LANES = 3,
    parameter int SLOTS     = 4,
    parameter int TAP_W     = 8,
    parameter int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
    // Transmit data path
    logic                          CMD_VALID;
    logic [NUM_LANES*SLOTS-1:0]    CMD_DATA;
    logic [NUM_LANES-1:0]          CMD_ODT;
    logic [NUM_LANES*SLOTS-1:0]    TX_DATA;
    logic [NUM_LANES*SLOTS-1:0]    OE_DATA;
    logic [NUM_LANES-1:0]          ODT_EN;

    // Delay adjust request/response
    logic                          ADJ_REQ;
    logic                          ADJ_READY;
    logic [LW-1:0]                 ADJ_LANE;
    logic                          ADJ_LOAD;
    logic                          ADJ_DIR;
    logic [TAP_W-1:0]              ADJ_STEPS;
    logic                          ADJ_DONE;
    logic                          ADJ_ERR;

    // Delay-line pins toward the IODs
    logic [NUM_LANES-1:0]          DELAY_LINE_MOVE;
    logic [NUM_LANES-1:0]          DELAY_LINE_DIRECTION;
    logic [NUM_LANES-1:0]          DELAY_LINE_LOAD;
    logic [NUM_LANES-1:0]          DELAY_LINE_OUT_OF_RANGE;

    // Tap tracking and status
    logic [NUM_LANES*TAP_W-1:0]    TAP_POS;
    logic [NUM_LANES-1:0]          OOR_STICKY;
    logic                          OOR_CLEAR;

    modport master (
        output CMD_VALID, CMD_DATA, CMD_ODT,
        output ADJ_REQ, ADJ_LANE, ADJ_LOAD, ADJ_DIR, ADJ_STEPS,
        output DELAY_LINE_OUT_OF_RANGE, OOR_CLEAR,
        input  TX_DATA, OE_DATA, ODT_EN,
        input  ADJ_READY, ADJ_DONE, ADJ_ERR,
        input  DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD,
        input  TAP_POS, OOR_STICKY
    );

    modport slave (
        input  CMD_VALID, CMD_DATA, CMD_ODT,
        input  ADJ_REQ, ADJ_LANE, ADJ_LOAD, ADJ_DIR, ADJ_STEPS,
        input  DELAY_LINE_OUT_OF_RANGE, OOR_CLEAR,
        output TX_DATA, OE_DATA, ODT_EN,
        output ADJ_READY, ADJ_DONE, ADJ_ERR,
        output DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD,
        output TAP_POS, OOR_STICKY
    );
endinterface

// File: rtl/ddr_ca_lane_ctrl.sv
// Fabric-side controller for a group of DDR3 address/command output lanes.
// Registers the per-lane 4:1 transmit words and enables, and sequences
// dynamic delay-line adjustments (load / move / direction) one lane at a time
// while tracking each lane's tap position and out-of-range status.
module ddr_ca_lane_ctrl #(
    parameter int NUM_LANES = 3,
    parameter int SLOTS     = 4,
    parameter int TAP_W     = 8,
    parameter int TAP_MAX   = 127,
    parameter int TAP_INIT  = 1,
    parameter int MOVE_GAP  = 4,
    parameter int OE_IDLE   = 1
) (
    input  logic                     FAB_CLK,
    input  logic                     ARST_N,
    ddr_ca_lane_ctrl_if.slave        bus
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int NS = NUM_LANES * SLOTS;
    localparam int GW = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

    localparam logic [TAP_W-1:0] TAP_MAX_T  = TAP_W'(TAP_MAX);
    localparam logic [TAP_W-1:0] TAP_INIT_T = TAP_W'(TAP_INIT);
    localparam logic [GW-1:0]    GAP_LAST   = GW'(MOVE_GAP - 1);
    localparam logic [LW:0]      LANES_T    = (LW+1)'(NUM_LANES);
    localparam logic [NS-1:0]    OE_IDLE_T  = (OE_IDLE != 0) ? '1 : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MOVE,
        S_GAP,
        S_LOAD,
        S_DONE
    } state_t;

    // A move is only legal while the tracked tap stays inside 0..TAP_MAX.
    function automatic logic move_legal(input logic [TAP_W-1:0] tap, input logic dir);
        if (dir)
            move_legal = (tap < TAP_MAX_T);
        else
            move_legal = (tap != '0);
    endfunction

    // Next tap position after one legal move in the given direction.
    function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] tap, input logic dir);
        if (dir)
            tap_step = tap + 1'b1;
        else
            tap_step = tap - 1'b1;
    endfunction

    // ---------------------------------------------------------------------
    // Transmit data path
    // ---------------------------------------------------------------------
    logic [NS-1:0]        tx_p1;
    logic [NS-1:0]        oe_p1;
    logic [NUM_LANES-1:0] odt_p1;

    // One-cycle register stage from the fabric command word to the IODs.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            tx_p1  <= '0;
            oe_p1  <= '0;
            odt_p1 <= '0;
        end else begin
            if (bus.CMD_VALID) begin
                tx_p1 <= bus.CMD_DATA;
                oe_p1 <= '1;
            end else begin
                tx_p1 <= '0;
                oe_p1 <= OE_IDLE_T;
            end
            odt_p1 <= bus.CMD_ODT;
        end
    end

    assign bus.TX_DATA = tx_p1;
    assign bus.OE_DATA = oe_p1;
    assign bus.ODT_EN  = odt_p1;

    // ---------------------------------------------------------------------
    // Delay adjust sequencer
    // ---------------------------------------------------------------------
    state_t               state;
    logic [LW-1:0]        lane_q;
    logic                 dir_q;
    logic [TAP_W-1:0]     remain_q;
    logic [GW-1:0]        gap_q;
    logic                 done_r;
    logic                 err_r;
    logic [NUM_LANES-1:0] move_r;
    logic [NUM_LANES-1:0] load_r;
    logic [NUM_LANES-1:0] dir_r;
    logic [TAP_W-1:0]     tap_q [NUM_LANES];
    logic                 lane_bad;

    // Lane numbers past the last implemented lane are rejected up front.
    assign lane_bad = ({1'b0, bus.ADJ_LANE} >= LANES_T);

    // Adjust FSM with registered pulse outputs. A move pulse is armed on the
    // edge into MOVE only when the step is legal, so in MOVE the pulse bit
    // itself tells whether the step happened or the request must abort.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state    <= S_IDLE;
            lane_q   <= '0;
            dir_q    <= 1'b0;
            remain_q <= '0;
            gap_q    <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            move_r   <= '0;
            load_r   <= '0;
            dir_r    <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                tap_q[l] <= TAP_INIT_T;
            end
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            move_r <= '0;
            load_r <= '0;
            case (state)
                S_IDLE: begin
                    if (bus.ADJ_REQ) begin
                        lane_q   <= bus.ADJ_LANE;
                        dir_q    <= bus.ADJ_DIR;
                        remain_q <= bus.ADJ_STEPS;
                        if (lane_bad) begin
                            state  <= S_DONE;
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end else if (bus.ADJ_LOAD) begin
                            state                 <= S_LOAD;
                            load_r[bus.ADJ_LANE]  <= 1'b1;
                            remain_q              <= '0;
                        end else if (bus.ADJ_STEPS == '0) begin
                            state  <= S_DONE;
                            done_r <= 1'b1;
                        end else begin
                            state                <= S_SETUP;
                            dir_r[bus.ADJ_LANE]  <= bus.ADJ_DIR;
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_MOVE;
                    if (move_legal(tap_q[lane_q], dir_q))
                        move_r[lane_q] <= 1'b1;
                end
                S_MOVE: begin
                    if (move_r[lane_q]) begin
                        tap_q[lane_q] <= tap_step(tap_q[lane_q], dir_q);
                        remain_q      <= remain_q - 1'b1;
                        gap_q         <= GAP_LAST;
                        state         <= S_GAP;
                    end else begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                        err_r  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    tap_q[lane_q] <= TAP_INIT_T;
                    gap_q         <= GAP_LAST;
                    state         <= S_GAP;
                end
                S_GAP: begin
                    if (bus.DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                        err_r  <= 1'b1;
                    end else if (gap_q == '0) begin
                        if (remain_q != '0) begin
                            state <= S_MOVE;
                            if (move_legal(tap_q[lane_q], dir_q))
                                move_r[lane_q] <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_r <= 1'b1;
                        end
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ADJ_READY            = (state == S_IDLE);
    assign bus.ADJ_DONE             = done_r;
    assign bus.ADJ_ERR              = err_r;
    assign bus.DELAY_LINE_MOVE      = move_r;
    assign bus.DELAY_LINE_LOAD      = load_r;
    assign bus.DELAY_LINE_DIRECTION = dir_r;

    // ---------------------------------------------------------------------
    // Out-of-range status
    // ---------------------------------------------------------------------
    logic [NUM_LANES-1:0] oor_sticky_q;

    // Sticky capture of the IOD range flags; a fresh flag beats a clear.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N)
            oor_sticky_q <= '0;
        else
            oor_sticky_q <= (oor_sticky_q & ~{NUM_LANES{bus.OOR_CLEAR}})
                            | bus.DELAY_LINE_OUT_OF_RANGE;
    end

    assign bus.OOR_STICKY = oor_sticky_q;

    // ---------------------------------------------------------------------
    // Tap position export
    // ---------------------------------------------------------------------
    logic [NUM_LANES*TAP_W-1:0] tap_flat;

    // Flatten the per-lane tap trackers, lane 0 in the low bits.
    always_comb begin
        tap_flat = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            tap_flat[l*TAP_W +: TAP_W] = tap_q[l];
        end
    end

    assign bus.TAP_POS = tap_flat;

endmodule

// File: tb/tb_ddr_ca_lane_ctrl.sv
// Directed bench for ddr_ca_lane_ctrl with NUM_LANES=3, MOVE_GAP=4,
// TAP_INIT=1, OE_IDLE=1. Expected values are hand-computed constants.
module tb_ddr_ca_lane_ctrl;

    localparam int NL = 3;
    localparam int SL = 4;
    localparam int TW = 8;

    logic FAB_CLK = 1'b0;
    logic ARST_N  = 1'b0;

    always #5 FAB_CLK = ~FAB_CLK;

    ddr_ca_lane_ctrl_if #(.NUM_LANES(NL), .SLOTS(SL), .TAP_W(TW)) bus();

    ddr_ca_lane_ctrl #(
        .NUM_LANES(NL), .SLOTS(SL), .TAP_W(TW), .TAP_MAX(127),
        .TAP_INIT(1), .MOVE_GAP(4), .OE_IDLE(1)
    ) dut (
        .FAB_CLK(FAB_CLK),
        .ARST_N (ARST_N),
        .bus    (bus)
    );

    int passed = 0;
    int total  = 0;

    // Results gathered while an adjust request runs
    int   mv_cyc[$];
    int   stray;
    int   load_cnt;
    int   load_cyc;
    int   done_cyc;
    int   dir_bad;
    int   ready_bad;
    logic err_at_done;
    int   done_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge FAB_CLK);
        #1;
    endtask

    function automatic int mvc(input int i);
        if (i < mv_cyc.size()) return mv_cyc[i];
        return -1;
    endfunction

    // Present a request for one cycle; returns in cycle k+1.
    task automatic issue(input logic [1:0] lane, input logic load, input logic dir,
                         input logic [7:0] steps);
        bus.ADJ_LANE  = lane;
        bus.ADJ_LOAD  = load;
        bus.ADJ_DIR   = dir;
        bus.ADJ_STEPS = steps;
        bus.ADJ_REQ   = 1'b1;
        tick();
        bus.ADJ_REQ   = 1'b0;
    endtask

    // Observe cycles k+1.. until ADJ_DONE or the cycle budget runs out.
    task automatic run_adj(input int lane, input logic dir, input logic chk_dir,
                           input int oor_lane, input int oor_at, input int max_cyc);
        mv_cyc.delete();
        stray = 0; load_cnt = 0; load_cyc = -1; done_cyc = -1;
        dir_bad = 0; ready_bad = 0; err_at_done = 1'b0;
        for (int j = 1; j <= max_cyc; j++) begin
            if (j > 1) tick();
            if (oor_lane >= 0)
                bus.DELAY_LINE_OUT_OF_RANGE = (j == oor_at) ? (3'b001 << oor_lane) : 3'b000;
            for (int l = 0; l < NL; l++) begin
                if (bus.DELAY_LINE_MOVE[l] === 1'b1) begin
                    if (l == lane) mv_cyc.push_back(j); else stray++;
                end
                if (bus.DELAY_LINE_LOAD[l] === 1'b1) begin
                    if (l == lane) begin load_cnt++; load_cyc = j; end else stray++;
                end
                if (chk_dir && l == lane && bus.DELAY_LINE_DIRECTION[l] !== dir) dir_bad++;
            end
            if (bus.ADJ_READY !== 1'b0) ready_bad++;
            if (bus.ADJ_DONE === 1'b1) begin
                done_cyc    = j;
                err_at_done = bus.ADJ_ERR;
                break;
            end
        end
    endtask

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_DATA  = '0;
        bus.CMD_ODT   = '0;
        bus.ADJ_REQ   = 1'b0;
        bus.ADJ_LANE  = '0;
        bus.ADJ_LOAD  = 1'b0;
        bus.ADJ_DIR   = 1'b0;
        bus.ADJ_STEPS = '0;
        bus.DELAY_LINE_OUT_OF_RANGE = '0;
        bus.OOR_CLEAR = 1'b0;

        // Reset values while held in reset
        #12;
        check("rst_tx",     bus.TX_DATA, 12'h000);
        check("rst_oe",     bus.OE_DATA, 12'h000);
        check("rst_odt",    bus.ODT_EN, 3'b000);
        check("rst_dl",     {bus.DELAY_LINE_MOVE, bus.DELAY_LINE_DIRECTION, bus.DELAY_LINE_LOAD}, 9'h000);
        check("rst_done",   {bus.ADJ_DONE, bus.ADJ_ERR}, 2'b00);
        check("rst_ready",  bus.ADJ_READY, 1'b1);
        check("rst_tap",    bus.TAP_POS, 24'h010101);
        check("rst_sticky", bus.OOR_STICKY, 3'b000);
        ARST_N = 1'b1;
        tick();

        // Data path: valid word, then idle word
        bus.CMD_VALID = 1'b1;
        bus.CMD_DATA  = 12'hA5C;
        bus.CMD_ODT   = 3'b101;
        tick();
        check("dp_tx_valid",  bus.TX_DATA, 12'hA5C);
        check("dp_oe_valid",  bus.OE_DATA, 12'hFFF);
        check("dp_odt_valid", bus.ODT_EN, 3'b101);
        bus.CMD_VALID = 1'b0;
        bus.CMD_DATA  = 12'h123;
        bus.CMD_ODT   = 3'b010;
        tick();
        check("dp_tx_idle",  bus.TX_DATA, 12'h000);
        check("dp_oe_idle",  bus.OE_DATA, 12'hFFF);
        check("dp_odt_idle", bus.ODT_EN, 3'b010);
        bus.CMD_ODT = 3'b000;

        // Lane 1, +3 steps
        issue(2'd1, 1'b0, 1'b1, 8'd3);
        run_adj(1, 1'b1, 1'b1, -1, 0, 40);
        check("l1_nmoves", mv_cyc.size(), 3);
        check("l1_move0",  mvc(0), 2);
        check("l1_move1",  mvc(1), 7);
        check("l1_move2",  mvc(2), 12);
        check("l1_done",   done_cyc, 17);
        check("l1_err",    err_at_done, 1'b0);
        check("l1_dir",    dir_bad, 0);
        check("l1_stray",  stray, 0);
        check("l1_busy",   ready_bad, 0);
        tick();
        check("l1_ready",  bus.ADJ_READY, 1'b1);
        check("l1_donelo", bus.ADJ_DONE, 1'b0);
        check("l1_tap",    bus.TAP_POS, 24'h010401);

        // Lane 0, -5 steps from tap 1: hits tap 0 and aborts
        issue(2'd0, 1'b0, 1'b0, 8'd5);
        run_adj(0, 1'b0, 1'b1, -1, 0, 40);
        check("l0_nmoves", mv_cyc.size(), 1);
        check("l0_move0",  mvc(0), 2);
        check("l0_done",   done_cyc, 8);
        check("l0_err",    err_at_done, 1'b1);
        check("l0_dir",    dir_bad, 0);
        tick();
        check("l0_tap",    bus.TAP_POS, 24'h010400);

        // Lane 2, +4 steps, out-of-range raised in the first gap cycle
        issue(2'd2, 1'b0, 1'b1, 8'd4);
        run_adj(2, 1'b1, 1'b1, 2, 3, 40);
        check("oor_nmoves", mv_cyc.size(), 1);
        check("oor_done",   done_cyc, 4);
        check("oor_err",    err_at_done, 1'b1);
        check("oor_sticky", bus.OOR_STICKY, 3'b100);
        bus.DELAY_LINE_OUT_OF_RANGE = 3'b000;
        tick();
        check("oor_tap",    bus.TAP_POS, 24'h020400);
        bus.OOR_CLEAR = 1'b1;
        tick();
        check("oor_clear",  bus.OOR_STICKY, 3'b000);
        bus.DELAY_LINE_OUT_OF_RANGE = 3'b100;
        tick();
        check("oor_setwins", bus.OOR_STICKY, 3'b100);
        bus.DELAY_LINE_OUT_OF_RANGE = 3'b000;
        tick();
        check("oor_clear2", bus.OOR_STICKY, 3'b000);
        bus.OOR_CLEAR = 1'b0;

        // Load lane 2 back to the initial tap
        issue(2'd2, 1'b1, 1'b0, 8'd9);
        run_adj(2, 1'b0, 1'b0, -1, 0, 40);
        check("ld_count",  load_cnt, 1);
        check("ld_cycle",  load_cyc, 1);
        check("ld_nmoves", mv_cyc.size(), 0);
        check("ld_done",   done_cyc, 6);
        check("ld_err",    err_at_done, 1'b0);
        tick();
        check("ld_tap",    bus.TAP_POS, 24'h010400);
        check("ld_dirs",   bus.DELAY_LINE_DIRECTION, 3'b110);

        // Nonexistent lane 3
        issue(2'd3, 1'b0, 1'b1, 8'd2);
        run_adj(3, 1'b1, 1'b0, -1, 0, 10);
        check("bad_done",  done_cyc, 1);
        check("bad_err",   err_at_done, 1'b1);
        check("bad_pulse", stray + mv_cyc.size() + load_cnt, 0);
        tick();
        check("bad_ready", bus.ADJ_READY, 1'b1);

        // Reset asserted during the first gap of a lane 1 request
        issue(2'd1, 1'b0, 1'b1, 8'd2);
        tick();
        tick();
        tick();
        check("ar_busy", bus.ADJ_READY, 1'b0);
        check("ar_tapmid", bus.TAP_POS, 24'h010500);
        ARST_N = 1'b0;
        #2;
        check("ar_dl",    {bus.DELAY_LINE_MOVE, bus.DELAY_LINE_DIRECTION, bus.DELAY_LINE_LOAD}, 9'h000);
        check("ar_ready", bus.ADJ_READY, 1'b1);
        check("ar_tap",   bus.TAP_POS, 24'h010101);
        check("ar_done",  {bus.ADJ_DONE, bus.ADJ_ERR}, 2'b00);
        #2;
        ARST_N = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.ADJ_DONE === 1'b1) done_seen++;
        end
        check("ar_nodone", done_seen, 0);
        check("ar_idle",   bus.ADJ_READY, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
